wasm_host_loader: RTL and testbench

WASM_HOST_LOADER -- requirements
Module: wasm_host_loader

---
 rtl/wasm_host_pkg.sv | 22 ++
 rtl/wasm_rb_fifo.sv | 57 +++++
 rtl/wasm_host_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_wasm_host_loader.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_host_pkg.sv
// Shared types and constants for the WASM host loader: state encoding, error codes
// and the core "work finished" state value.
package wasm_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FINISH    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_READBACK  = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;
    localparam logic [1:0] ERR_EARLY = 2'b11;

    localparam logic [1:0] WORK_DONE = 2'b11;

endpackage

// File: rtl/wasm_rb_fifo.sv
// Small synchronous FIFO buffering line-memory readback data ahead of the output stream.
// Depth need not be a power of two; writes while full are discarded.
module wasm_rb_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (cnt == '0);
    assign do_wr   = wr_en && (int'(cnt) < DEPTH);
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage carries no reset; only the pointers decide what is visible.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/wasm_host_loader.sv
// Host-side job sequencer: packs a byte stream into instruction words for the core,
// waits for the core to finish, then streams a window of line memory back out.
module wasm_host_loader
    import wasm_host_pkg::*;
#(
    parameter int INSTR_W  = 64,
    parameter int INSTR_AW = 15,
    parameter int LINE_AW  = 9,
    parameter int LINE_DW  = 32,
    parameter int RD_LAT   = 1,
    parameter int TMO_W    = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LINE_AW-1:0]  rb_base,
    input  logic [LINE_AW:0]    rb_count,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    input  logic                s_last,
    output logic                instr_wr_vld,
    input  logic                instr_wr_rdy,
    output logic [INSTR_AW-1:0] instr_wr_addr,
    output logic [INSTR_W-1:0]  instr_wr_data,
    output logic                instr_wr_finish,
    input  logic [1:0]          work_state,
    output logic                line_rd_rdy,
    output logic [LINE_AW-1:0]  line_rd_addr,
    input  logic [LINE_DW-1:0]  line_rd_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [LINE_DW-1:0]  m_data,
    output logic                m_last,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err,
    output logic [31:0]         cycle_cnt
);

    localparam int BYTES = INSTR_W / 8;
    localparam int BIW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [BIW-1:0] LAST_BYTE = BIW'(BYTES - 1);
    localparam logic [LINE_AW:0] ONE_LEFT = (LINE_AW + 1)'(1);

    state_t              state_q, state_d;
    logic [1:0]          err_q, err_d;
    logic                done_q, done_d;
    logic                finish_q, finish_d;

    logic [INSTR_W-1:0]  word_q;
    logic [BIW-1:0]      bidx_q;
    logic                pend_q;
    logic                pend_last_q;
    logic [INSTR_AW:0]   wcnt_q;

    logic [LINE_AW-1:0]  rd_addr_q;
    logic [LINE_AW:0]    rb_count_q;
    logic [LINE_AW:0]    issue_left_q;
    logic [LINE_AW:0]    out_left_q;
    logic [RD_LAT-1:0]   pipe_q;
    logic [TMO_W-1:0]    tmo_q;
    logic [TMO_W-1:0]    tmo_inc;
    logic [31:0]         cyc_q;

    logic                start_ok;
    logic                busy_int;
    logic                byte_fire;
    logic                word_fire;
    logic                ovf;
    logic                tmo_hit;
    logic                issue;
    logic                capture;
    logic                pop;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       inflight;

    assign busy_int  = state_q inside {ST_LOAD, ST_FINISH, ST_WAIT_DONE, ST_READBACK};
    assign start_ok  = start && !busy_int;
    assign s_ready   = (state_q == ST_LOAD) && !pend_q;
    assign byte_fire = s_valid && s_ready;
    assign ovf       = (state_q == ST_LOAD) && pend_q && wcnt_q[INSTR_AW];
    assign instr_wr_vld  = (state_q == ST_LOAD) && pend_q && !wcnt_q[INSTR_AW];
    assign word_fire     = instr_wr_vld && instr_wr_rdy;
    assign instr_wr_addr = wcnt_q[INSTR_AW-1:0];
    assign instr_wr_data = word_q;
    assign tmo_inc   = tmo_q + 1'b1;
    assign tmo_hit   = &tmo_inc;

    // Reads already issued to line memory still own a FIFO slot, so they count against room.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
    end

    assign issue = (state_q == ST_READBACK) && (issue_left_q != '0)
                 && ((int'(fifo_count) + int'(inflight)) < DEPTH);
    assign capture      = pipe_q[RD_LAT-1];
    assign pop          = m_valid && m_ready;
    assign line_rd_rdy  = issue;
    assign line_rd_addr = rd_addr_q;
    assign m_valid      = !fifo_empty;
    assign m_last       = m_valid && (out_left_q == ONE_LEFT);

    assign busy            = busy_int;
    assign done            = done_q;
    assign err             = err_q;
    assign instr_wr_finish = finish_q;
    assign cycle_cnt       = cyc_q;

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        done_d   = done_q;
        finish_d = finish_q;
        if (start_ok) begin
            state_d  = ST_LOAD;
            err_d    = ERR_NONE;
            done_d   = 1'b0;
            finish_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (work_state == WORK_DONE) begin
                        state_d = ST_ERR;
                        err_d   = ERR_EARLY;
                    end else if (ovf) begin
                        state_d = ST_ERR;
                        err_d   = ERR_OVF;
                    end else if (word_fire && pend_last_q) begin
                        state_d = ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    finish_d = 1'b1;
                    state_d  = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (work_state == WORK_DONE) begin
                        if (rb_count_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_READBACK;
                        end
                    end else if (tmo_hit) begin
                        state_d = ST_ERR;
                        err_d   = ERR_TMO;
                    end
                end
                ST_READBACK: begin
                    if (pop && (out_left_q == ONE_LEFT)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            done_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            done_q   <= done_d;
            finish_q <= finish_d;
        end
    end

    // Byte packing: a word is held stable until the core takes it, then the buffer is zeroed
    // so a short final word comes out with its unfilled upper bytes cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= '0;
            bidx_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            wcnt_q      <= '0;
        end else if (start_ok) begin
            word_q      <= '0;
            bidx_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            wcnt_q      <= '0;
        end else if (state_q == ST_LOAD) begin
            if (byte_fire) begin
                word_q[int'(bidx_q)*8 +: 8] <= s_data;
                if ((bidx_q == LAST_BYTE) || s_last) begin
                    pend_q      <= 1'b1;
                    pend_last_q <= s_last;
                    bidx_q      <= '0;
                end else begin
                    bidx_q <= bidx_q + 1'b1;
                end
            end
            if (word_fire) begin
                pend_q <= 1'b0;
                word_q <= '0;
                wcnt_q <= wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q    <= '0;
            rb_count_q   <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            pipe_q       <= '0;
            tmo_q        <= '0;
            cyc_q        <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | RD_LAT'(issue);
            tmo_q  <= (state_q == ST_WAIT_DONE) ? (tmo_hit ? tmo_q : tmo_inc) : '0;
            if (start_ok) begin
                rd_addr_q    <= rb_base;
                rb_count_q   <= rb_count;
                issue_left_q <= rb_count;
                out_left_q   <= rb_count;
                cyc_q        <= '0;
            end else begin
                if (issue) begin
                    rd_addr_q    <= rd_addr_q + 1'b1;
                    issue_left_q <= issue_left_q - 1'b1;
                end
                if (pop) begin
                    out_left_q <= out_left_q - 1'b1;
                end
                if (busy_int && (cyc_q != '1)) begin
                    cyc_q <= cyc_q + 32'd1;
                end
            end
        end
    end

    wasm_rb_fifo #(
        .W     (LINE_DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_rb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (capture),
        .wr_data (line_rd_data),
        .rd_en   (pop),
        .rd_data (m_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_wasm_host_loader.sv
// Self-checking bench for wasm_host_loader: table of complete jobs plus hand-written
// sequences for timeout, early completion, overflow and mid-readback reset.
module tb_wasm_host_loader;

    localparam int INSTR_W  = 64;
    localparam int INSTR_AW = 3;
    localparam int LINE_AW  = 9;
    localparam int LINE_DW  = 32;
    localparam int RD_LAT   = 2;
    localparam int TMO_W    = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [LINE_AW-1:0]  rb_base;
    logic [LINE_AW:0]    rb_count;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          s_data;
    logic                s_last;
    logic                instr_wr_vld;
    logic                instr_wr_rdy;
    logic [INSTR_AW-1:0] instr_wr_addr;
    logic [INSTR_W-1:0]  instr_wr_data;
    logic                instr_wr_finish;
    logic [1:0]          work_state;
    logic                line_rd_rdy;
    logic [LINE_AW-1:0]  line_rd_addr;
    logic [LINE_DW-1:0]  line_rd_data;
    logic                m_valid;
    logic                m_ready;
    logic [LINE_DW-1:0]  m_data;
    logic                m_last;
    logic                busy;
    logic                done;
    logic [1:0]          err;
    logic [31:0]         cycle_cnt;

    wasm_host_loader #(
        .INSTR_W(INSTR_W), .INSTR_AW(INSTR_AW), .LINE_AW(LINE_AW),
        .LINE_DW(LINE_DW), .RD_LAT(RD_LAT), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rb_base(rb_base), .rb_count(rb_count),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .instr_wr_vld(instr_wr_vld), .instr_wr_rdy(instr_wr_rdy),
        .instr_wr_addr(instr_wr_addr), .instr_wr_data(instr_wr_data),
        .instr_wr_finish(instr_wr_finish), .work_state(work_state),
        .line_rd_rdy(line_rd_rdy), .line_rd_addr(line_rd_addr), .line_rd_data(line_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .err(err), .cycle_cnt(cycle_cnt)
    );

    typedef struct {
        int               nbytes;
        logic [7:0]       seed;
        int               rdy_mode;
        int               mrdy_mode;
        logic [8:0]       base;
        logic [9:0]       count;
        int               exp_nwords;
        logic [2:0][63:0] exp_w;
    } job_t;

    job_t jobs [3];

    int n_checks = 0;
    int n_pass   = 0;
    int rdy_mode = 0;
    int mrdy_mode = 0;
    int rdy_phase = 0;
    int busy_cyc = 0;
    int wd_cyc   = 0;
    int hold_viol = 0;
    int sr_viol   = 0;
    bit hold_pend = 0;
    logic [INSTR_AW-1:0] hold_addr;
    logic [INSTR_W-1:0]  hold_data;

    logic [INSTR_AW-1:0] wr_addr_q [$];
    logic [INSTR_W-1:0]  wr_data_q [$];
    logic [LINE_AW-1:0]  iss_q [$];
    logic [LINE_DW-1:0]  rb_data_q [$];
    logic                rb_last_q [$];

    logic [LINE_AW-1:0]  rdq0;
    logic [LINE_AW-1:0]  rdq1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line memory model: each location holds C0DE0000 | address, delivered RD_LAT cycles later.
    always @(posedge clk) begin
        rdq0 <= line_rd_addr;
        rdq1 <= rdq0;
    end
    assign line_rd_data = 32'hC0DE_0000 | {23'd0, rdq1};

    initial begin
        instr_wr_rdy = 1'b1;
        m_ready      = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            instr_wr_rdy = (rdy_mode == 0) ? 1'b1 : ((rdy_phase % 3) == 0);
            rdy_phase    = rdy_phase + 1;
            m_ready      = (mrdy_mode == 0) ? 1'b1 :
                           (mrdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (busy) busy_cyc = busy_cyc + 1;
        if (busy && instr_wr_finish) wd_cyc = wd_cyc + 1;
        if (hold_pend && (!instr_wr_vld || instr_wr_addr != hold_addr || instr_wr_data != hold_data))
            hold_viol = hold_viol + 1;
        hold_pend = instr_wr_vld && !instr_wr_rdy;
        hold_addr = instr_wr_addr;
        hold_data = instr_wr_data;
        if (s_ready && instr_wr_vld) sr_viol = sr_viol + 1;
        if (instr_wr_vld && instr_wr_rdy) begin
            wr_addr_q.push_back(instr_wr_addr);
            wr_data_q.push_back(instr_wr_data);
        end
        if (line_rd_rdy) iss_q.push_back(line_rd_addr);
        if (m_valid && m_ready) begin
            rb_data_q.push_back(m_data);
            rb_last_q.push_back(m_last);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit condMet(input int which);
        case (which)
            0:       return instr_wr_finish;
            1:       return done;
            2:       return !busy;
            default: return m_valid;
        endcase
    endfunction

    task automatic waitSignal(input string name, input int which, input int limit);
        bit met;
        met = 1'b0;
        for (int c = 0; c < limit && !met; c++) begin
            @(negedge clk);
            met = condMet(which);
        end
        checkOutput(name, 64'(met), 64'd1);
    endtask

    task automatic clearLogs();
        wr_addr_q.delete();
        wr_data_q.delete();
        iss_q.delete();
        rb_data_q.delete();
        rb_last_q.delete();
        hold_viol = 0;
        sr_viol   = 0;
    endtask

    task automatic startJob(input logic [8:0] base, input logic [9:0] count);
        @(posedge clk);
        #1;
        rb_base  = base;
        rb_count = count;
        start    = 1'b1;
        busy_cyc = 0;
        wd_cyc   = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendBytes(input int n, input logic [7:0] seed, output int sent);
        bit hs;
        bit abort;
        sent  = 0;
        abort = 1'b0;
        for (int i = 0; i < n && !abort; i++) begin
            s_valid = 1'b1;
            s_data  = seed + 8'(i);
            s_last  = (i == n - 1);
            hs = 1'b0;
            for (int g = 0; g < 100 && !hs && !abort; g++) begin
                @(negedge clk);
                if (!busy) begin
                    abort = 1'b1;
                end else begin
                    hs = s_ready;
                    @(posedge clk);
                    #1;
                end
            end
            if (hs) sent = sent + 1;
            else abort = 1'b1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic applyStimulus(input job_t jb);
        int         sent;
        logic [8:0] a;
        clearLogs();
        rdy_mode  = jb.rdy_mode;
        mrdy_mode = jb.mrdy_mode;
        startJob(jb.base, jb.count);
        sendBytes(jb.nbytes, jb.seed, sent);
        checkOutput("bytes_sent", 64'(sent), 64'(jb.nbytes));
        waitSignal("finish_rise", 0, 20);
        checkOutput("nwords", 64'(wr_data_q.size()), 64'(jb.exp_nwords));
        for (int i = 0; i < jb.exp_nwords && i < wr_data_q.size(); i++) begin
            checkOutput($sformatf("wr_addr[%0d]", i), 64'(wr_addr_q[i]), 64'(i));
            checkOutput($sformatf("wr_data[%0d]", i), wr_data_q[i], jb.exp_w[i]);
        end
        checkOutput("hold_stable", 64'(hold_viol), 64'd0);
        checkOutput("sready_while_pending", 64'(sr_viol), 64'd0);
        @(posedge clk);
        #1;
        work_state = 2'b11;
        if (jb.count == 10'd0) begin
            @(negedge clk);
            checkOutput("done_not_yet", 64'(done), 64'd0);
            @(negedge clk);
            checkOutput("done_next_cycle", 64'(done), 64'd1);
        end else begin
            waitSignal("done_rise", 1, 400);
        end
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        checkOutput("err_after_done", 64'(err), 64'd0);
        checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(busy_cyc));
        checkOutput("n_issues", 64'(iss_q.size()), 64'(jb.count));
        checkOutput("n_readback", 64'(rb_data_q.size()), 64'(jb.count));
        for (int i = 0; i < int'(jb.count) && i < iss_q.size() && i < rb_data_q.size(); i++) begin
            a = jb.base + 9'(i);
            checkOutput($sformatf("rd_addr[%0d]", i), 64'(iss_q[i]), 64'(a));
            checkOutput($sformatf("m_data[%0d]", i), 64'(rb_data_q[i]), 64'(32'hC0DE_0000 | {23'd0, a}));
            checkOutput($sformatf("m_last[%0d]", i), 64'(rb_last_q[i]), 64'(i == int'(jb.count) - 1));
        end
        @(posedge clk);
        #1;
        work_state = 2'b00;
    endtask

    initial begin
        int sent;
        rst_n = 1'b0; start = 1'b0; rb_base = '0; rb_count = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; work_state = 2'b00;

        jobs[0] = '{nbytes: 17, seed: 8'h01, rdy_mode: 0, mrdy_mode: 0, base: 9'h010, count: 10'd3,
                    exp_nwords: 3, exp_w: {64'h0000_0000_0000_0011, 64'h100F_0E0D_0C0B_0A09, 64'h0807_0605_0403_0201}};
        jobs[1] = '{nbytes: 10, seed: 8'h40, rdy_mode: 1, mrdy_mode: 1, base: 9'h1FE, count: 10'd4,
                    exp_nwords: 2, exp_w: {64'h0, 64'h0000_0000_0000_4948, 64'h4746_4544_4342_4140}};
        jobs[2] = '{nbytes: 8, seed: 8'hA0, rdy_mode: 0, mrdy_mode: 0, base: 9'h000, count: 10'd0,
                    exp_nwords: 1, exp_w: {64'h0, 64'h0, 64'hA7A6_A5A4_A3A2_A1A0}};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", 64'({s_ready, instr_wr_vld, instr_wr_finish, line_rd_rdy, m_valid, busy, done, err}), 64'd0);
        checkOutput("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int j = 0; j < 3; j++) begin
            $display("[TB] job %0d", j);
            applyStimulus(jobs[j]);
        end

        $display("[TB] timeout sequence");
        clearLogs();
        rdy_mode = 0; mrdy_mode = 0;
        startJob(9'h000, 10'd1);
        sendBytes(1, 8'hEE, sent);
        waitSignal("tmo_busy_low", 2, 60);
        checkOutput("tmo_wait_cycles", 64'(wd_cyc), 64'd15);
        checkOutput("tmo_err", 64'(err), 64'h2);
        checkOutput("tmo_finish_held", 64'(instr_wr_finish), 64'd1);
        checkOutput("tmo_no_done", 64'(done), 64'd0);

        $display("[TB] early completion sequence");
        startJob(9'h000, 10'd1);
        checkOutput("early_err_cleared", 64'(err), 64'd0);
        work_state = 2'b11;
        @(negedge clk);
        @(negedge clk);
        checkOutput("early_err", 64'(err), 64'h3);
        checkOutput("early_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        work_state = 2'b00;

        $display("[TB] overflow sequence");
        clearLogs();
        startJob(9'h000, 10'd1);
        sendBytes(72, 8'h00, sent);
        waitSignal("ovf_busy_low", 2, 20);
        checkOutput("ovf_err", 64'(err), 64'h1);
        checkOutput("ovf_nwords", 64'(wr_data_q.size()), 64'd8);
        if (wr_data_q.size() == 8) begin
            checkOutput("ovf_first_word", wr_data_q[0], 64'h0706_0504_0302_0100);
            checkOutput("ovf_last_addr", 64'(wr_addr_q[7]), 64'd7);
            checkOutput("ovf_last_word", wr_data_q[7], 64'h3F3E_3D3C_3B3A_3938);
        end

        $display("[TB] reset during readback");
        clearLogs();
        rdy_mode = 0; mrdy_mode = 2;
        startJob(9'h020, 10'd6);
        sendBytes(3, 8'h55, sent);
        waitSignal("rst_finish_rise", 0, 20);
        @(posedge clk);
        #1;
        work_state = 2'b11;
        waitSignal("rst_fifo_filling", 3, 40);
        @(negedge clk);
        checkOutput("rst_pre_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_flags", 64'({s_ready, instr_wr_vld, instr_wr_finish, line_rd_rdy, m_valid, busy, done, err}), 64'd0);
        checkOutput("rst_mid_cycle_cnt", 64'(cycle_cnt), 64'd0);
        work_state = 2'b00;
        mrdy_mode  = 0;
        @(negedge clk);
        checkOutput("rst_held_flags", 64'({m_valid, busy, line_rd_rdy}), 64'd0);
        #2;
        rst_n = 1'b1;
        applyStimulus(jobs[0]);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
